dom_mask_prng: RTL



---
 rtl/dom_mask_prng.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dom_mask_prng.sv
// Fresh-randomness source for the DOM masked S-box: 32-bit Fibonacci LFSR,
// advanced four steps per mask pair, with seed handshake and warm-up discard.
module dom_mask_prng #(
    parameter int unsigned WARMUP   = 32,
    parameter logic [31:0] TAPS     = 32'h80200003,
    parameter logic [31:0] ZERO_SUB = 32'hACE1ACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        seed_valid,
    input  logic [31:0] seed_data,
    output logic        seed_ready,
    input  logic        req,
    output logic [1:0]  Z0,
    output logic [1:0]  Z1,
    output logic        z_valid,
    output logic        starved
);

    localparam int unsigned LFSR_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STEPS  = 4;

    typedef enum logic [1:0] {
        S_UNSEEDED = 2'd0,
        S_WARMUP   = 2'd1,
        S_RUN      = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [LFSR_W-1:0]   lfsr, lfsr_nx, lfsr_adv, load_val;
    logic [CNT_W-1:0]    warm_cnt, warm_cnt_nx;
    logic [1:0]          z0_nx, z1_nx;
    logic                z_valid_nx, starved_nx, seed_ready_nx;
    logic                accept;

    // One shift: feedback is the parity of the tapped state bits.
    function automatic logic [LFSR_W-1:0] step(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = ^(s & TAPS);
        return {s[LFSR_W-2:0], fb};
    endfunction

    function automatic logic [LFSR_W-1:0] advance(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] t;
        t = s;
        for (int unsigned i = 0; i < STEPS; i++) begin
            t = step(t);
        end
        return t;
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced.
    assign load_val = (seed_data == '0) ? ZERO_SUB : seed_data;
    assign lfsr_adv = advance(lfsr);
    assign accept   = seed_valid && seed_ready;

    always_comb begin
        state_nx    = state;
        lfsr_nx     = lfsr;
        warm_cnt_nx = warm_cnt;
        z0_nx       = Z0;
        z1_nx       = Z1;
        z_valid_nx  = 1'b0;
        starved_nx  = starved;

        case (state)
            S_UNSEEDED: begin
                if (req) starved_nx = 1'b1;
                if (accept) begin
                    lfsr_nx     = load_val;
                    warm_cnt_nx = '0;
                    state_nx    = S_WARMUP;
                end
            end
            S_WARMUP: begin
                if (req) starved_nx = 1'b1;
                lfsr_nx     = lfsr_adv;
                warm_cnt_nx = CNT_W'(warm_cnt + CNT_W'(1));
                if (warm_cnt == CNT_W'(WARMUP - 1)) state_nx = S_RUN;
            end
            S_RUN: begin
                // A reseed takes priority over a coincident request.
                if (accept) begin
                    if (req) starved_nx = 1'b1;
                    lfsr_nx     = load_val;
                    warm_cnt_nx = '0;
                    state_nx    = S_WARMUP;
                end else if (req) begin
                    lfsr_nx    = lfsr_adv;
                    z0_nx      = lfsr_adv[1:0];
                    z1_nx      = lfsr_adv[3:2];
                    z_valid_nx = 1'b1;
                end
            end
            default: state_nx = S_UNSEEDED;
        endcase

        seed_ready_nx = (state_nx != S_WARMUP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_UNSEEDED;
            lfsr       <= '0;
            warm_cnt   <= '0;
            Z0         <= 2'b00;
            Z1         <= 2'b00;
            z_valid    <= 1'b0;
            starved    <= 1'b0;
            seed_ready <= 1'b1;
        end else begin
            state      <= state_nx;
            lfsr       <= lfsr_nx;
            warm_cnt   <= warm_cnt_nx;
            Z0         <= z0_nx;
            Z1         <= z1_nx;
            z_valid    <= z_valid_nx;
            starved    <= starved_nx;
            seed_ready <= seed_ready_nx;
        end
    end

endmodule
